// File: rtl/freq_avg_buffer.sv
// freq_avg_buffer: captures four asynchronous channel counts, averages
// 2^AVG_LOG2 measurement windows per record and queues records in a FIFO.
module freq_avg_buffer #(
    parameter int AVG_LOG2      = 3,
    parameter int FIFO_DEPTH    = 4,
    parameter int WINDOW_CYCLES = 100011
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    input  logic [127:0] freq,
    output logic [127:0] m_data,
    output logic         m_valid,
    input  logic         m_ready,
    output logic         overflow,
    output logic [15:0]  record_count
);

    localparam int SW = 32 + AVG_LOG2;
    localparam int TW = $clog2(WINDOW_CYCLES);
    localparam int IW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [TW-1:0] T_MAX   = TW'(WINDOW_CYCLES - 1);
    localparam logic [IW-1:0] IDX_MAX = IW'((1 << AVG_LOG2) - 1);
    localparam logic [CW-1:0] C_FULL  = CW'(FIFO_DEPTH);

    logic [127:0] r_s1;
    logic [127:0] r_s2;
    logic [127:0] r_last;
    logic [TW-1:0] r_timer;
    logic          r_armed;
    logic [IW-1:0] r_idx;
    logic [SW-1:0] r_sum [4];
    logic [127:0]  r_avg;
    logic          r_avg_vld;
    logic [127:0]  r_pipe;
    logic          r_pipe_vld;
    logic [127:0]  r_mem [FIFO_DEPTH];
    logic [PW-1:0] r_wr;
    logic [PW-1:0] r_rd;
    logic [CW-1:0] r_cnt;
    logic          r_ovf;
    logic [15:0]   r_rec_cnt;

    logic          w_stable;
    logic          w_accept;
    logic          w_last_idx;
    logic [SW-1:0] w_tot [4];
    logic [31:0]   w_lane [4];
    logic [127:0]  w_new_avg;
    logic          w_pop;
    logic          w_full;
    logic          w_push;

    assign w_stable   = (r_s2 == r_s1);
    assign w_accept   = enable && w_stable &&
                        ((r_s2 != r_last) || (r_timer == T_MAX));
    assign w_last_idx = (r_idx == IDX_MAX);

    for (genvar g = 0; g < 4; g++) begin : g_lane
        assign w_tot[g]  = r_sum[g] + SW'(r_s2[32*g +: 32]);
        assign w_lane[g] = 32'(w_tot[g] >> AVG_LOG2);
    end

    assign w_new_avg = {w_lane[3], w_lane[2], w_lane[1], w_lane[0]};

    assign w_pop  = (r_cnt != '0) && m_ready;
    assign w_full = (r_cnt == C_FULL);
    assign w_push = r_pipe_vld && (!w_full || w_pop);

    assign m_valid      = (r_cnt != '0);
    assign m_data       = m_valid ? r_mem[r_rd] : '0;
    assign overflow     = r_ovf;
    assign record_count = r_rec_cnt;

    // Two-stage capture of the foreign-domain counts.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1 <= '0;
            r_s2 <= '0;
        end else begin
            r_s1 <= freq;
            r_s2 <= r_s1;
        end
    end

    // Re-accept timer: restarts on accept, held at zero while idle.
    always_ff @(posedge clk) begin
        if (reset || !enable || w_accept) begin
            r_timer <= '0;
        end else if (r_timer != T_MAX) begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Accept bookkeeping and per-channel accumulation into an average.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_last    <= '0;
            r_armed   <= 1'b1;
            r_idx     <= '0;
            r_avg     <= '0;
            r_avg_vld <= 1'b0;
            for (int c = 0; c < 4; c++) r_sum[c] <= '0;
        end else begin
            r_avg_vld <= 1'b0;
            if (!enable) begin
                r_armed <= 1'b1;
                r_idx   <= '0;
                for (int c = 0; c < 4; c++) r_sum[c] <= '0;
            end else if (w_accept) begin
                r_last  <= r_s2;
                r_armed <= 1'b0;
                if (!r_armed) begin
                    if (w_last_idx) begin
                        r_idx     <= '0;
                        r_avg     <= w_new_avg;
                        r_avg_vld <= 1'b1;
                        for (int c = 0; c < 4; c++) r_sum[c] <= '0;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                        for (int c = 0; c < 4; c++) r_sum[c] <= w_tot[c];
                    end
                end
            end
        end
    end

    // Second pipeline stage between the averager and the FIFO.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_pipe     <= '0;
            r_pipe_vld <= 1'b0;
        end else begin
            r_pipe     <= r_avg;
            r_pipe_vld <= r_avg_vld;
        end
    end

    // FIFO storage; contents are only observed while occupied.
    always_ff @(posedge clk) begin
        if (!reset && w_push) begin
            r_mem[r_wr] <= r_pipe;
        end
    end

    // FIFO pointers, occupancy, overflow flag and push counter.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr      <= '0;
            r_rd      <= '0;
            r_cnt     <= '0;
            r_ovf     <= 1'b0;
            r_rec_cnt <= '0;
        end else begin
            if (w_push) begin
                r_wr      <= r_wr + PW'(1);
                r_rec_cnt <= r_rec_cnt + 16'd1;
            end
            if (w_pop) begin
                r_rd <= r_rd + PW'(1);
            end
            if (w_push && !w_pop) begin
                r_cnt <= r_cnt + CW'(1);
            end else if (w_pop && !w_push) begin
                r_cnt <= r_cnt - CW'(1);
            end
            if (r_pipe_vld && !w_push) begin
                r_ovf <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_freq_avg_buffer.sv
// Randomized bench for freq_avg_buffer with a queue-based reference model
// and a few hand-computed scenario checks.
module tb_freq_avg_buffer;

    localparam int L     = 3;
    localparam int N     = 1 << L;
    localparam int DEPTH = 4;
    localparam int WC    = 16;

    logic         clk = 1'b0;
    logic         reset;
    logic         enable;
    logic [127:0] freq;
    logic [127:0] m_data;
    logic         m_valid;
    logic         m_ready;
    logic         overflow;
    logic [15:0]  record_count;

    int checks   = 0;
    int failures = 0;

    freq_avg_buffer #(
        .AVG_LOG2(L),
        .FIFO_DEPTH(DEPTH),
        .WINDOW_CYCLES(WC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .enable(enable),
        .freq(freq),
        .m_data(m_data),
        .m_valid(m_valid),
        .m_ready(m_ready),
        .overflow(overflow),
        .record_count(record_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [127:0] act,
                       input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        int           due;
        logic [127:0] d;
    } pend_t;

    logic [127:0] ms1, ms2, mlast;
    int           mtimer;
    bit           marmed;
    logic [127:0] macc[$];
    logic [127:0] mfifo[$];
    pend_t        mpend[$];
    bit           movf;
    int           mcnt;
    int           cyc = 0;
    bit           mstarted = 0;

    always @(posedge clk) begin : model
        bit           pop;
        bit           acc;
        pend_t        p;
        logic [127:0] avg;
        longint unsigned s;
        cyc++;
        mstarted = 1;
        if (reset) begin
            ms1 = '0; ms2 = '0; mlast = '0;
            mtimer = 0; marmed = 1;
            macc.delete(); mfifo.delete(); mpend.delete();
            movf = 0; mcnt = 0;
        end else begin
            pop = (mfifo.size() != 0) && m_ready;
            acc = enable && (ms2 == ms1) &&
                  ((ms2 != mlast) || (mtimer == WC - 1));
            if (pop) void'(mfifo.pop_front());
            if (mpend.size() != 0 && mpend[0].due == cyc) begin
                p = mpend.pop_front();
                if (mfifo.size() < DEPTH) begin
                    mfifo.push_back(p.d);
                    mcnt = (mcnt + 1) % 65536;
                end else begin
                    movf = 1;
                end
            end
            if (!enable) begin
                mtimer = 0; marmed = 1; macc.delete();
            end else if (acc) begin
                mtimer = 0;
                mlast = ms2;
                if (marmed) begin
                    marmed = 0;
                end else begin
                    macc.push_back(ms2);
                    if (macc.size() == N) begin
                        for (int c = 0; c < 4; c++) begin
                            s = 0;
                            foreach (macc[k]) s += 64'(macc[k][32*c +: 32]);
                            avg[32*c +: 32] = 32'(s / N);
                        end
                        mpend.push_back('{cyc + 2, avg});
                        macc.delete();
                    end
                end
            end else if (mtimer < WC - 1) begin
                mtimer++;
            end
            ms2 = ms1;
            ms1 = freq;
        end
    end

    // Cycle-by-cycle comparison against the model.
    always @(negedge clk) begin
        if (mstarted) begin
            chk("m_valid", 128'(m_valid), 128'(mfifo.size() != 0));
            chk("m_data", m_data, (mfifo.size() != 0) ? mfifo[0] : '0);
            chk("overflow", 128'(overflow), 128'(movf));
            chk("record_count", 128'(record_count), 128'(mcnt));
        end
    end

    // ---------------- stimulus ----------------
    task automatic ramp(input bit pulse);
        reset = 1'b1;
        enable = 1'b1;
        m_ready = 1'b0;
        freq = {4{32'd777}};
        repeat (2) @(negedge clk);
        chk("rst_valid", 128'(m_valid), 128'd0);
        chk("rst_data", m_data, 128'd0);
        chk("rst_count", 128'(record_count), 128'd0);
        chk("rst_ovf", 128'(overflow), 128'd0);
        reset = 1'b0;
        repeat (WC) @(negedge clk);
        for (int v = 0; v < N; v++) begin
            freq = {4{32'(1000 + v)}};
            for (int j = 1; j <= WC; j++) begin
                @(negedge clk);
                if (v == N - 1) begin
                    if (pulse) begin
                        if (j == 3) reset = 1'b1;
                        if (j == 4) reset = 1'b0;
                        if (j == 6) begin
                            chk("rstpulse_valid", 128'(m_valid), 128'd0);
                            chk("rstpulse_count", 128'(record_count), 128'd0);
                        end
                    end else begin
                        if (j == 4) chk("lat_early", 128'(m_valid), 128'd0);
                        if (j == 5) begin
                            chk("lat_valid", 128'(m_valid), 128'd1);
                            chk("avg_1003", m_data, {4{32'd1003}});
                            chk("count_1", 128'(record_count), 128'd1);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        int len;
        int pct;
        reset = 1'b1;
        enable = 1'b0;
        m_ready = 1'b0;
        freq = '0;
        @(negedge clk);

        ramp(1'b1);
        ramp(1'b0);

        // Constant input: timeout re-accepts keep producing 5000 records.
        freq = {4{32'd5000}};
        repeat (4 * N * WC + 40) @(negedge clk);
        chk("ovf_set", 128'(overflow), 128'd1);
        chk("ovf_count", 128'(record_count), 128'd4);
        chk("ovf_head", m_data, {4{32'd1003}});
        enable = 1'b0;
        repeat (4) @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        chk("drain_2nd", m_data, {4{32'd5000}});
        repeat (3) @(negedge clk);
        chk("drain_empty", 128'(m_valid), 128'd0);
        chk("drain_ovf", 128'(overflow), 128'd1);

        // Randomized traffic.
        pct = 90;
        for (int s = 0; s < 300; s++) begin
            if (s % 50 == 0) pct = (pct == 90) ? 15 : 90;
            len = $urandom_range(1, 2 * WC);
            if ($urandom_range(0, 7) != 0) begin
                for (int c = 0; c < 4; c++) begin
                    if ($urandom_range(0, 1) == 1)
                        freq[32*c +: 32] = $urandom;
                    else
                        freq[32*c +: 32] = $urandom_range(0, 20);
                end
            end
            enable = ($urandom_range(0, 15) != 0);
            for (int j = 0; j < len; j++) begin
                m_ready = ($urandom_range(0, 99) < pct);
                reset = ($urandom_range(0, 399) == 0);
                @(negedge clk);
            end
            reset = 1'b0;
        end
        enable = 1'b1;
        m_ready = 1'b1;
        repeat (20) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/freq_avg_buffer.md
FREQ_AVG_BUFFER -- requirements
Module: freq_avg_buffer

Interface
REQ-001 Parameter: AVG_LOG2, default 3, log2 of the number of accepted windows averaged into one record (legal 0..8).
REQ-002 Parameter: FIFO_DEPTH, default 4, record FIFO depth (power of two, 2..16).
REQ-003 Parameter: WINDOW_CYCLES, default 100011, clk cycles in one counter measurement window (re-accept timeout).
REQ-004 Port: clk  input  1  single clock; all logic on posedge clk.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: enable  input  1  high = accept and average samples; low = idle.
REQ-007 Port: freq  input  128  four 32-bit channel counts, channel i in bits [32i+31:32i]; driven from outside the clk domain; changes at most once per window.
REQ-008 Port: m_data  output  128  head FIFO record, four 32-bit averages, same channel packing as freq.
REQ-009 Port: m_valid  output  1  FIFO non-empty; m_data valid.
REQ-010 Port: m_ready  input  1  consumer accepts head record when high with m_valid.
REQ-011 Port: overflow  output  1  sticky: a record was dropped because the FIFO was full.
REQ-012 Port: record_count  output  16  number of records pushed since reset; wraps 65535 -> 0.

Function
REQ-013 Input capture: freq registered through two stages (s1, s2); s2 is "stable" when s2 == s1.
REQ-014 Accept condition (evaluated each edge, enable high): stable AND (s2 != last_accepted OR timer == WINDOW_CYCLES-1).
REQ-015 Timer: counts clk cycles, cleared on every accept and whenever enable is low; saturates at WINDOW_CYCLES-1.
REQ-016 On accept: last_accepted <= s2; timer <= 0; sample enters accumulation pipeline.
REQ-017 First accept after enable rises (or after reset) is a partial window: updates last_accepted, discarded from accumulation.
REQ-018 Accumulation: per channel unsigned sum of width 32+AVG_LOG2, no overflow possible; sample index counts 0..2^AVG_LOG2-1.
REQ-019 On accept with index == 2^AVG_LOG2-1: average_i = (sum_i + sample_i) >> AVG_LOG2, truncated; sums and index cleared same edge.
REQ-020 Latency: record pushed to FIFO and visible on m_valid/m_data 2 edges after the edge at which the final sample is accepted.
REQ-021 Handshake: pop on edge where m_valid && m_ready; m_data holds head stable while m_valid && !m_ready.
REQ-022 Push when FIFO full and no pop same edge: record dropped, overflow <= 1, record_count not incremented.
REQ-023 Push and pop same edge when full: both occur, no overflow, occupancy unchanged.
REQ-024 Push into empty FIFO with m_ready high: m_valid rises next edge; no bypass.
REQ-025 record_count increments on every successful push.
REQ-026 enable low: no accepts; sums, index and timer cleared synchronously; in-flight average (REQ-020) still pushed; FIFO and overflow unaffected.
REQ-027 AVG_LOG2 = 0: every non-discarded accept produces one record equal to the sample.

Reset
REQ-028 reset high at any edge: m_valid=0, m_data=0, overflow=0, record_count=0, FIFO empty, sums/index/timer=0, s1/s2/last_accepted=0, first-accept discard flag armed.
REQ-029 Reset mid-accumulation or mid-pipeline discards partial sums and in-flight records; no push follows.
REQ-030 Reset has priority over enable, accept and handshake.

Verification
REQ-031 AVG_LOG2=3, enable high, freq steps every 100011 cycles through one junk then 8 windows all channels = 1000..1007 -> one record, each lane 1003, m_valid 2 edges after 8th accept.
REQ-032 freq constant 5000 on all lanes for 10 windows, AVG_LOG2=0 -> timeout re-accepts; first discarded, 9 records of 5000, record_count=9.
REQ-033 m_ready held low, 5 records produced with FIFO_DEPTH=4 -> 4 stored in order, 5th dropped, overflow=1, record_count=4; then m_ready high drains 4, m_valid falls.
REQ-034 FIFO full, push coincident with pop -> no overflow, occupancy stays 4, order preserved.
REQ-035 enable dropped after 5 of 8 windows, re-raised -> partial sums lost, next accept discarded, next record averages only 8 fresh windows.
REQ-036 reset pulsed 1 edge after final accept -> no record appears, all outputs 0.
